// File: rtl/key_event_debounce_if.sv
// Key pads in, debounced levels and one-cycle event pulses out.
// The master side drives the pads; the slave side is the debouncer.
interface key_event_debounce_if #(
    parameter int N = 1
);
    logic         enable;
    logic [N-1:0] key_in;
    logic [N-1:0] key_state;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] repeat_pulse;

    modport master (
        output enable, key_in,
        input  key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  enable, key_in,
        output key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_event_debounce.sv
// N-channel key debouncer with press, release, long-press and auto-repeat events.
// Each channel is an independent lane: 2-flop synchroniser followed by a debounce/hold FSM.
module key_event_debounce_lane #(
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_NUM    = 240000,
    parameter int LONG_NUM   = 6000000,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_NUM = 1200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    localparam int CW       = $clog2(CNT_NUM);
    localparam int HOLD_MAX = (LONG_NUM > REPEAT_NUM) ? LONG_NUM : REPEAT_NUM;
    localparam int HW       = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_NUM - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_NUM - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_NUM - 1);
    localparam logic          RELEASED  = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t        state;
    logic          sync1, sync2, ks, long_done;
    logic [CW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign ks = sync2 ^ RELEASED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                long_done <= 1'b0;
                key_state <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (ks) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                    PRESS_WAIT: begin
                        if (!ks) state <= IDLE;
                        else if (deb_cnt == CNT_LAST) begin
                            state       <= PRESSED;
                            key_state   <= 1'b1;
                            press_pulse <= 1'b1;
                            hold_cnt    <= '0;
                            long_done   <= 1'b0;
                        end else deb_cnt <= deb_cnt + CW'(1);
                    end
                    PRESSED: begin
                        // hold_cnt is frozen while a possible release is being debounced
                        if (!ks) begin
                            state   <= RELEASE_WAIT;
                            deb_cnt <= '0;
                        end else if (!long_done) begin
                            if (hold_cnt == LONG_LAST) begin
                                long_pulse <= 1'b1;
                                long_done  <= 1'b1;
                                hold_cnt   <= '0;
                            end else hold_cnt <= hold_cnt + HW'(1);
                        end else if (REPEAT_EN != 0) begin
                            if (hold_cnt == REP_LAST) begin
                                repeat_pulse <= 1'b1;
                                hold_cnt     <= '0;
                            end else hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (ks) state <= PRESSED;
                        else if (deb_cnt == CNT_LAST) begin
                            state         <= IDLE;
                            key_state     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else deb_cnt <= deb_cnt + CW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module key_event_debounce #(
    parameter int N          = 1,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_NUM    = 240000,
    parameter int LONG_NUM   = 6000000,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_NUM = 1200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_event_debounce_if.slave  bus
);
    logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;

    for (genvar i = 0; i < N; i++) begin : g_lane
        key_event_debounce_lane #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .CNT_NUM    (CNT_NUM),
            .LONG_NUM   (LONG_NUM),
            .REPEAT_EN  (REPEAT_EN),
            .REPEAT_NUM (REPEAT_NUM)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable        (bus.enable),
            .key_in        (bus.key_in[i]),
            .key_state     (key_state[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    assign bus.key_state     = key_state;
    assign bus.press_pulse   = press_pulse;
    assign bus.release_pulse = release_pulse;
    assign bus.long_pulse    = long_pulse;
    assign bus.repeat_pulse  = repeat_pulse;
endmodule

// File: tb/tb_key_event_debounce.sv
// Scoreboard bench for key_event_debounce: every expected pulse is queued with its
// absolute clock edge when the stimulus is scheduled, and popped as pulses appear.
module tb_key_event_debounce;
    localparam int N = 4;
    localparam int CNT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [47:0] exp_q[$];

    key_event_debounce_if #(.N(N)) bus ();

    key_event_debounce #(
        .N(N), .ACTIVE_LOW(1), .CNT_NUM(CNT), .LONG_NUM(20), .REPEAT_EN(1), .REPEAT_NUM(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event record: {edge, release, long, repeat, press}
    function automatic void push_ev(input int c, input logic [3:0] prs, input logic [3:0] rpt,
                                    input logic [3:0] lng, input logic [3:0] rel);
        exp_q.push_back({32'(c), rel, lng, rpt, prs});
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edge e is the first edge at which sync stage 1 samples v.
    task automatic drive_at(input int e, input logic [N-1:0] v);
        wait_cyc(e - 1);
        bus.key_in = v;
    endtask

    always @(negedge clk) begin
        logic [47:0] obs;
        obs = {32'(cyc), bus.release_pulse, bus.long_pulse, bus.repeat_pulse, bus.press_pulse};
        if (|obs[15:0]) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", obs, 48'h0);
            else chk("pulse_event", obs, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        bus.enable = 1'b1;
        bus.key_in = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.key_state, bus.press_pulse, bus.release_pulse,
                              bus.long_pulse, bus.repeat_pulse}, 20'h0);
        rst_n = 1'b1;

        // Clean press on ch0, held 40 clks: long at +30, repeats every 5 after
        b = cyc + 2;
        push_ev(b + 10, 4'h1, 4'h0, 4'h0, 4'h0);
        push_ev(b + 30, 4'h0, 4'h0, 4'h1, 4'h0);
        push_ev(b + 35, 4'h0, 4'h1, 4'h0, 4'h0);
        push_ev(b + 40, 4'h0, 4'h1, 4'h0, 4'h0);
        push_ev(b + 50, 4'h0, 4'h0, 4'h0, 4'h1);
        drive_at(b, 4'hE);
        wait_cyc(b + 9);
        chk("s1_state_before_press", bus.key_state, 4'h0);
        wait_cyc(b + 20);
        chk("s1_state_held", bus.key_state, 4'h1);
        drive_at(b + 40, 4'hF);
        wait_cyc(b + 60);
        chk("s1_state_released", bus.key_state, 4'h0);

        // Bouncing ch1, 3-clk runs never reach CNT stable cycles
        b = cyc + 2;
        for (int i = 0; i < 10; i++) drive_at(b + 3 * i, (i % 2 == 0) ? 4'hD : 4'hF);
        wait_cyc(b + 14);
        chk("s2_state_bouncing", bus.key_state, 4'h0);
        wait_cyc(b + 50);
        chk("s2_state_settled", bus.key_state, 4'h0);

        // ch2: 4-clk release glitch while hold_cnt=10. Counting stops for the four
        // ks=0 edges and for the edge returning to PRESSED, so long moves from +30 to +35.
        b = cyc + 2;
        push_ev(b + 10, 4'h4, 4'h0, 4'h0, 4'h0);
        push_ev(b + 35, 4'h0, 4'h0, 4'h4, 4'h0);
        push_ev(b + 40, 4'h0, 4'h4, 4'h0, 4'h0);
        push_ev(b + 52, 4'h0, 4'h0, 4'h0, 4'h4);
        drive_at(b, 4'hB);
        drive_at(b + 19, 4'hF);
        drive_at(b + 23, 4'hB);
        chk("s3_state_in_glitch", bus.key_state, 4'h4);
        drive_at(b + 42, 4'hF);
        wait_cyc(b + 65);
        chk("s3_state_released", bus.key_state, 4'h0);

        // All four channels together
        b = cyc + 2;
        push_ev(b + 10, 4'hF, 4'h0, 4'h0, 4'h0);
        push_ev(b + 22, 4'h0, 4'h0, 4'h0, 4'hF);
        drive_at(b, 4'h0);
        wait_cyc(b + 11);
        chk("s4_state_all", bus.key_state, 4'hF);
        drive_at(b + 12, 4'hF);
        wait_cyc(b + 35);
        chk("s4_state_released", bus.key_state, 4'h0);

        // Abort: enable low for one edge while ch0 is pressed, then re-debounce.
        // Sync is already settled, so IDLE->PRESS_WAIT happens on the first enabled edge.
        b = cyc + 2;
        push_ev(b + 10, 4'h1, 4'h0, 4'h0, 4'h0);
        push_ev(b + 24, 4'h1, 4'h0, 4'h0, 4'h0);
        drive_at(b, 4'hE);
        wait_cyc(b + 14);
        chk("s5_state_before_disable", bus.key_state, 4'h1);
        bus.enable = 1'b0;
        wait_cyc(b + 15);
        chk("s5_state_disabled", bus.key_state, 4'h0);
        bus.enable = 1'b1;
        drive_at(b + 26, 4'hC);
        wait_cyc(b + 30);
        chk("s5_state_repressed", bus.key_state, 4'h1);
        wait_cyc(b + 31);
        #2;
        rst_n = 1'b0;
        bus.key_in = 4'hF;
        #1;
        chk("s5_async_reset", {bus.key_state, bus.press_pulse, bus.release_pulse,
                               bus.long_pulse, bus.repeat_pulse}, 20'h0);
        wait_cyc(b + 33);
        rst_n = 1'b1;
        wait_cyc(b + 70);
        chk("s5_state_after_reset", bus.key_state, 4'h0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
